// File: rtl/exc_ctrl_if.sv
//------------------------------------------------------------------------------
// exc_ctrl_if : MEM-stage event / CP0 state bundle and exception commit outputs
// Revision    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface exc_ctrl_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delay_slot_i;
  logic        exc_syscall_i;
  logic        exc_ri_i;
  logic        exc_trap_i;
  logic        exc_ov_i;
  logic        eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        exc_we_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_epc_o;
  logic        exc_bd_o;
  logic        exl_set_o;
  logic        exl_clr_o;
  logic        busy_o;

  modport master (
    output mem_valid_i, mem_pc_i, mem_in_delay_slot_i,
    output exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, eret_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o,
    input  exl_set_o, exl_clr_o, busy_o
  );

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_in_delay_slot_i,
    input  exc_syscall_i, exc_ri_i, exc_trap_i, exc_ov_i, eret_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output flush_o, new_pc_o, exc_we_o, exc_code_o, exc_epc_o, exc_bd_o,
    output exl_set_o, exl_clr_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/exc_ctrl.sv
//------------------------------------------------------------------------------
// exc_ctrl : MEM-stage exception/interrupt/ERET commit controller with flush FSM
//            Optional macro INT_VECTORED_EN: Cause.IV selects EXC_VECTOR+0x200.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned FLUSH_LEN  = 1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  exc_ctrl_if.slave  bus
);

  localparam logic [2:0] c_CNT_LOAD  = 3'(FLUSH_LEN - 1);
  localparam logic [4:0] c_CODE_INT  = 5'h00;
  localparam logic [4:0] c_CODE_RI   = 5'h0a;
  localparam logic [4:0] c_CODE_SYS  = 5'h08;
  localparam logic [4:0] c_CODE_TRAP = 5'h0d;
  localparam logic [4:0] c_CODE_OV   = 5'h0c;
`ifdef INT_VECTORED_EN
  localparam logic [31:0] c_VEC_OFFSET = 32'h0000_0200;
`endif

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_flush;
  logic        r_busy;
  logic [31:0] r_new_pc;
  logic        r_exc_we;
  logic [4:0]  r_exc_code;
  logic [31:0] r_exc_epc;
  logic        r_exc_bd;
  logic        r_exl_set;
  logic        r_exl_clr;

  logic [31:0] w_eff_status;
  logic [31:0] w_eff_cause;
  logic [31:0] w_eff_epc;
  logic        w_int_pend;
  logic        w_is_exc;
  logic        w_take;
  logic [4:0]  w_code;
  logic [31:0] w_epc;
  logic [31:0] w_vec;
  logic        w_unused;

  // A CP0 write still in WB must be seen by the event decided this cycle.
  always_comb begin
    w_eff_status = bus.cp0_status_i;
    w_eff_epc    = bus.cp0_epc_i;
    w_eff_cause  = bus.cp0_cause_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) w_eff_status = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) w_eff_epc = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) w_eff_cause[9:8] = bus.wb_cp0_data_i[9:8];
  end

  assign w_int_pend = (|(w_eff_status[15:8] & w_eff_cause[15:8]))
                      && w_eff_status[0] && !w_eff_status[1];

  assign w_is_exc = w_int_pend || bus.exc_ri_i || bus.exc_syscall_i
                    || bus.exc_trap_i || bus.exc_ov_i;

  assign w_take = bus.mem_valid_i && (r_state == S_IDLE) && (w_is_exc || bus.eret_i);

  always_comb begin
    w_code = c_CODE_OV;
    if (w_int_pend)             w_code = c_CODE_INT;
    else if (bus.exc_ri_i)      w_code = c_CODE_RI;
    else if (bus.exc_syscall_i) w_code = c_CODE_SYS;
    else if (bus.exc_trap_i)    w_code = c_CODE_TRAP;
  end

  assign w_epc = bus.mem_in_delay_slot_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;

`ifdef INT_VECTORED_EN
  assign w_vec = (w_int_pend && w_eff_cause[23]) ? (EXC_VECTOR + c_VEC_OFFSET) : EXC_VECTOR;
`else
  assign w_vec = EXC_VECTOR;
`endif

  assign w_unused = &{1'b0, w_eff_status[31:16], w_eff_status[7:2],
                      w_eff_cause[31:16], w_eff_cause[7:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_flush    <= 1'b0;
      r_busy     <= 1'b0;
      r_new_pc   <= 32'd0;
      r_exc_we   <= 1'b0;
      r_exc_code <= 5'd0;
      r_exc_epc  <= 32'd0;
      r_exc_bd   <= 1'b0;
      r_exl_set  <= 1'b0;
      r_exl_clr  <= 1'b0;
    end else begin
      r_exc_we  <= 1'b0;
      r_exl_set <= 1'b0;
      r_exl_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_FLUSH;
            r_cnt   <= c_CNT_LOAD;
            r_flush <= 1'b1;
            r_busy  <= 1'b1;
            if (w_is_exc) begin
              r_new_pc   <= w_vec;
              r_exc_we   <= 1'b1;
              r_exl_set  <= 1'b1;
              r_exc_code <= w_code;
              r_exc_epc  <= w_epc;
              r_exc_bd   <= bus.mem_in_delay_slot_i;
            end else begin
              r_new_pc  <= w_eff_epc;
              r_exl_clr <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (r_cnt == 3'd0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.flush_o    = r_flush;
  assign bus.busy_o     = r_busy;
  assign bus.new_pc_o   = r_new_pc;
  assign bus.exc_we_o   = r_exc_we;
  assign bus.exc_code_o = r_exc_code;
  assign bus.exc_epc_o  = r_exc_epc;
  assign bus.exc_bd_o   = r_exc_bd;
  assign bus.exl_set_o  = r_exl_set;
  assign bus.exl_clr_o  = r_exl_clr;

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
//------------------------------------------------------------------------------
// tb_exc_ctrl : directed + random bench for exc_ctrl (FLUSH_LEN 1 and 3 instances)
// Revision    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_exc_ctrl;

  localparam logic [31:0] c_VEC = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mem_valid, ds, sys, ri, trap, ov, eret, wb_we;
  logic [31:0] mem_pc, st, ca, ep, wb_data;
  logic [4:0]  wb_addr;

  int n_tests = 0;
  int n_fail  = 0;

  exc_ctrl_if bus1 ();
  exc_ctrl_if bus3 ();

  always_comb begin
    bus1.mem_valid_i = mem_valid;  bus3.mem_valid_i = mem_valid;
    bus1.mem_pc_i = mem_pc;        bus3.mem_pc_i = mem_pc;
    bus1.mem_in_delay_slot_i = ds; bus3.mem_in_delay_slot_i = ds;
    bus1.exc_syscall_i = sys;      bus3.exc_syscall_i = sys;
    bus1.exc_ri_i = ri;            bus3.exc_ri_i = ri;
    bus1.exc_trap_i = trap;        bus3.exc_trap_i = trap;
    bus1.exc_ov_i = ov;            bus3.exc_ov_i = ov;
    bus1.eret_i = eret;            bus3.eret_i = eret;
    bus1.cp0_status_i = st;        bus3.cp0_status_i = st;
    bus1.cp0_cause_i = ca;         bus3.cp0_cause_i = ca;
    bus1.cp0_epc_i = ep;           bus3.cp0_epc_i = ep;
    bus1.wb_cp0_we_i = wb_we;      bus3.wb_cp0_we_i = wb_we;
    bus1.wb_cp0_waddr_i = wb_addr; bus3.wb_cp0_waddr_i = wb_addr;
    bus1.wb_cp0_data_i = wb_data;  bus3.wb_cp0_data_i = wb_data;
  end

  exc_ctrl #(.EXC_VECTOR(c_VEC), .FLUSH_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  exc_ctrl #(.EXC_VECTOR(c_VEC), .FLUSH_LEN(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // Reference: rem counts flush cycles still owed after the current edge.
  typedef struct {
    int          rem;
    logic        flush, we, set, clr, bd, clean;
    logic [4:0]  code;
    logic [31:0] epc, npc;
  } exp_t;

  exp_t m1, m3;
  logic m_ready = 1'b0;

  function automatic exp_t step(exp_t cur, int fl);
    exp_t n;
    logic [31:0] es, ec, ee;
    logic irq;
    n = cur;
    n.we = 1'b0; n.set = 1'b0; n.clr = 1'b0;
    if (!rst) begin
      n = '{default: 0};
      n.clean = 1'b1;
      return n;
    end
    if (cur.rem > 0) begin
      n.rem   = cur.rem - 1;
      n.flush = (n.rem > 0);
      return n;
    end
    n.flush = 1'b0;
    if (!mem_valid) return n;
    es = (wb_we && wb_addr == 5'd12) ? wb_data : st;
    ee = (wb_we && wb_addr == 5'd14) ? wb_data : ep;
    ec = ca;
    if (wb_we && wb_addr == 5'd13) ec[9:8] = wb_data[9:8];
    irq = 1'b0;
    for (int b = 8; b < 16; b++) if (es[b] && ec[b]) irq = 1'b1;
    irq = irq && es[0] && !es[1];
    if (irq || ri || sys || trap || ov) begin
      n.rem = fl; n.flush = 1'b1; n.we = 1'b1; n.set = 1'b1; n.clean = 1'b0;
      n.code = irq ? 5'd0 : ri ? 5'd10 : sys ? 5'd8 : trap ? 5'd13 : 5'd12;
      n.bd   = ds;
      n.epc  = ds ? mem_pc - 32'd4 : mem_pc;
      n.npc  = c_VEC;
`ifdef INT_VECTORED_EN
      if (irq && ec[23]) n.npc = c_VEC + 32'h200;
`endif
    end else if (eret) begin
      n.rem = fl; n.flush = 1'b1; n.clr = 1'b1; n.clean = 1'b0;
      n.npc = ee;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= step(m1, 1);
    m3 <= step(m3, 3);
    m_ready <= 1'b1;
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(string t, exp_t e, logic f, logic b, logic we, logic se,
                           logic cl, logic [4:0] cd, logic [31:0] epc, logic bd,
                           logic [31:0] np);
    cmp({t, ".flush"}, 32'(f), 32'(e.flush));
    cmp({t, ".busy"}, 32'(b), 32'(e.flush));
    cmp({t, ".exc_we"}, 32'(we), 32'(e.we));
    cmp({t, ".exl_set"}, 32'(se), 32'(e.set));
    cmp({t, ".exl_clr"}, 32'(cl), 32'(e.clr));
    if (e.we || e.clean) begin
      cmp({t, ".code"}, 32'(cd), 32'(e.code));
      cmp({t, ".epc"}, epc, e.epc);
      cmp({t, ".bd"}, 32'(bd), 32'(e.bd));
    end
    if (e.flush || e.clean) cmp({t, ".new_pc"}, np, e.npc);
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      check_dut("d1", m1, bus1.flush_o, bus1.busy_o, bus1.exc_we_o, bus1.exl_set_o,
                bus1.exl_clr_o, bus1.exc_code_o, bus1.exc_epc_o, bus1.exc_bd_o, bus1.new_pc_o);
      check_dut("d3", m3, bus3.flush_o, bus3.busy_o, bus3.exc_we_o, bus3.exl_set_o,
                bus3.exl_clr_o, bus3.exc_code_o, bus3.exc_epc_o, bus3.exc_bd_o, bus3.new_pc_o);
    end
  end

  task automatic clear_in();
    mem_valid = 1'b0; mem_pc = 32'd0; ds = 1'b0;
    sys = 1'b0; ri = 1'b0; trap = 1'b0; ov = 1'b0; eret = 1'b0;
    st = 32'd0; ca = 32'd0; ep = 32'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic idle(int n);
    clear_in();
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] iv_exp;
    clear_in();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("reset flush", 32'(bus1.flush_o), 32'd0);
    cmp("reset new_pc", bus1.new_pc_o, 32'd0);
    cmp("reset busy3", 32'(bus3.busy_o), 32'd0);

    // syscall, not in delay slot
    mem_valid = 1'b1; mem_pc = 32'h1000; sys = 1'b1;
    @(negedge clk);
    clear_in();
    cmp("sys flush", 32'(bus1.flush_o), 32'd1);
    cmp("sys new_pc", bus1.new_pc_o, 32'h20);
    cmp("sys exc_we", 32'(bus1.exc_we_o), 32'd1);
    cmp("sys code", 32'(bus1.exc_code_o), 32'h08);
    cmp("sys epc", bus1.exc_epc_o, 32'h1000);
    cmp("sys bd", 32'(bus1.exc_bd_o), 32'd0);
    cmp("sys exl_set", 32'(bus1.exl_set_o), 32'd1);
    cmp("model sys code", 32'(m1.code), 32'h08);
    @(negedge clk);
    cmp("sys after flush", 32'(bus1.flush_o), 32'd0);
    cmp("sys after we", 32'(bus1.exc_we_o), 32'd0);
    cmp("sys after set", 32'(bus1.exl_set_o), 32'd0);
    idle(4);

    // interrupt masks RI, delay slot
    mem_valid = 1'b1; st = 32'h0000_8001; ca = 32'h0000_8000; ri = 1'b1;
    mem_pc = 32'h2000; ds = 1'b1;
    @(negedge clk);
    clear_in();
    cmp("irq code", 32'(bus1.exc_code_o), 32'h00);
    cmp("irq epc", bus1.exc_epc_o, 32'h1FFC);
    cmp("irq bd", 32'(bus1.exc_bd_o), 32'd1);
    cmp("model irq epc", m1.epc, 32'h1FFC);
    idle(4);

    // ERET with EPC bypass
    mem_valid = 1'b1; eret = 1'b1; ep = 32'h100;
    wb_we = 1'b1; wb_addr = 5'd14; wb_data = 32'h300;
    @(negedge clk);
    clear_in();
    cmp("eret new_pc", bus1.new_pc_o, 32'h300);
    cmp("eret exl_clr", 32'(bus1.exl_clr_o), 32'd1);
    cmp("eret exc_we", 32'(bus1.exc_we_o), 32'd0);
    cmp("model eret npc", m1.npc, 32'h300);
    idle(4);

    // EXL blocks, then status bypass releases the interrupt
    mem_valid = 1'b1; st = 32'h0000_8003; ca = 32'h0000_8000;
    @(negedge clk);
    cmp("exl blocks", 32'(bus1.flush_o), 32'd0);
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000_8001;
    @(negedge clk);
    clear_in();
    cmp("bypass irq flush", 32'(bus1.flush_o), 32'd1);
    cmp("bypass irq code", 32'(bus1.exc_code_o), 32'h00);
    idle(4);

    // FLUSH_LEN=3: second event ignored, then reset mid-flush
    mem_valid = 1'b1; ov = 1'b1;
    @(negedge clk);
    clear_in();
    mem_valid = 1'b1; sys = 1'b1;
    cmp("ov3 code", 32'(bus3.exc_code_o), 32'h0c);
    cmp("ov3 flush c1", 32'(bus3.flush_o), 32'd1);
    @(negedge clk);
    clear_in();
    cmp("ov3 flush c2", 32'(bus3.flush_o), 32'd1);
    cmp("ov3 no 2nd strobe", 32'(bus3.exc_we_o), 32'd0);
    @(negedge clk);
    cmp("ov3 flush c3", 32'(bus3.flush_o), 32'd1);
    cmp("model ov3 c3", 32'(m3.flush), 32'd1);
    @(negedge clk);
    cmp("ov3 flush end", 32'(bus3.flush_o), 32'd0);
    idle(2);
    mem_valid = 1'b1; ov = 1'b1;
    @(negedge clk);
    clear_in();
    @(negedge clk);
    cmp("ov3 r flush c2", 32'(bus3.flush_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cmp("midrst flush", 32'(bus3.flush_o), 32'd0);
    cmp("midrst busy", 32'(bus3.busy_o), 32'd0);
    cmp("midrst new_pc", bus3.new_pc_o, 32'd0);
    cmp("midrst code", 32'(bus3.exc_code_o), 32'd0);
    idle(2);

    // vectored interrupt / trap
`ifdef INT_VECTORED_EN
    iv_exp = 32'h220;
`else
    iv_exp = 32'h20;
`endif
    mem_valid = 1'b1; st = 32'h0000_8001; ca = 32'h0080_8000;
    @(negedge clk);
    clear_in();
    cmp("iv irq new_pc", bus1.new_pc_o, iv_exp);
    idle(4);
    mem_valid = 1'b1; trap = 1'b1; ca = 32'h0080_0000;
    @(negedge clk);
    clear_in();
    cmp("iv trap new_pc", bus1.new_pc_o, 32'h20);
    cmp("trap code", 32'(bus1.exc_code_o), 32'h0d);
    idle(4);

    // PC wrap in delay slot
    mem_valid = 1'b1; sys = 1'b1; ds = 1'b1; mem_pc = 32'd0;
    @(negedge clk);
    clear_in();
    cmp("wrap epc", bus1.exc_epc_o, 32'hFFFF_FFFC);
    cmp("wrap bd", 32'(bus1.exc_bd_o), 32'd1);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 63) != 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_pc    = $urandom;
      ds        = 1'($urandom_range(0, 1));
      sys       = ($urandom_range(0, 7) == 0);
      ri        = ($urandom_range(0, 7) == 0);
      trap      = ($urandom_range(0, 7) == 0);
      ov        = ($urandom_range(0, 7) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       st = 32'h0000_8001;
        1:       st = 32'h0000_8003;
        2:       st = 32'h0000_FF01;
        default: st = $urandom;
      endcase
      ca      = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0080_FF00) : 32'($urandom);
      ep      = $urandom;
      wb_we   = ($urandom_range(0, 3) == 0);
      wb_addr = 5'(12 + $urandom_range(0, 3));
      wb_data = $urandom;
      @(negedge clk);
    end
    rst = 1'b1;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
